// File: rtl/insn_decode_if.sv
// Fetch-side and execute-side handshake signals of the RV32I decode stage.
interface insn_decode_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_insn;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      rd;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [XLEN-1:0] imm;
   logic [3:0]      alu_op;
   logic            sub_sra;
   logic            use_imm;
   logic            reg_we;
   logic            mem_rd;
   logic            mem_wr;
   logic            branch;
   logic            jump;
   logic            muldiv;
   logic            illegal;

   modport slave (
      input  in_valid, in_insn, in_pc, out_ready,
      output in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op, sub_sra,
             use_imm, reg_we, mem_rd, mem_wr, branch, jump, muldiv, illegal
   );

   modport master (
      output in_valid, in_insn, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, rd, rs1, rs2, imm, alu_op, sub_sra,
             use_imm, reg_we, mem_rd, mem_wr, branch, jump, muldiv, illegal
   );
endinterface

// File: rtl/insn_decode_stage.sv
// RV32I decode stage: the incoming instruction is decoded combinationally into a
// registered output bundle, backed by one skid entry so in_ready comes from a flop.
module insn_decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   insn_decode_if.slave io
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu_op;
      logic            sub_sra;
      logic            use_imm;
      logic            reg_we;
      logic            mem_rd;
      logic            mem_wr;
      logic            branch;
      logic            jump;
      logic            muldiv;
      logic            illegal;
   } bundle_t;

   function automatic bundle_t decode(input logic [31:0] insn, input logic [XLEN-1:0] pc);
      bundle_t            b;
      logic [6:0]         opc;
      logic [2:0]         f3;
      logic [6:0]         f7;
      logic signed [31:0] imm32;
      logic is_op, is_opimm, is_load, is_store, is_branch;
      logic is_jal, is_jalr, is_lui, is_auipc;
      logic known, bad, md, alt, zero_f3;
      opc       = insn[6:0];
      f3        = insn[14:12];
      f7        = insn[31:25];
      is_op     = (opc == OPC_OP);
      is_opimm  = (opc == OPC_OPIMM);
      is_load   = (opc == OPC_LOAD);
      is_store  = (opc == OPC_STORE);
      is_branch = (opc == OPC_BRANCH);
      is_jal    = (opc == OPC_JAL);
      is_jalr   = (opc == OPC_JALR);
      is_lui    = (opc == OPC_LUI);
      is_auipc  = (opc == OPC_AUIPC);
      known     = is_op | is_opimm | is_load | is_store | is_branch |
                  is_jal | is_jalr | is_lui | is_auipc;
      md        = is_op && (f7 == 7'b0000001);

      bad = !known;
      if (is_op)
         bad = !((f7 == 7'b0000000) || (f7 == 7'b0100000) || (md && ENABLE_M)) ||
               ((f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101)));
      if (is_opimm && (f3 == 3'b001))
         bad = (f7 != 7'b0000000);
      if (is_opimm && (f3 == 3'b101))
         bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      if (is_jalr)   bad = (f3 != 3'b000);
      if (is_load)   bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      if (is_store)  bad = (f3 > 3'b010);
      if (is_branch) bad = (f3[2:1] == 2'b01);

      imm32 = '0;
      if (is_opimm || is_load || is_jalr)
         imm32 = {{20{insn[31]}}, insn[31:20]};
      else if (is_store)
         imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      else if (is_branch)
         imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      else if (is_lui || is_auipc)
         imm32 = {insn[31:12], 12'b0};
      else if (is_jal)
         imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

      // Generalised "second flavour" select: SUB/SRA/SRAI, signed/unsigned compares, branches
      alt = is_branch ||
            ((is_op || is_opimm) && (f3[2:1] == 2'b01)) ||
            (is_op && insn[30] && ((f3 == 3'b000) || (f3 == 3'b101))) ||
            (is_opimm && insn[30] && (f3 == 3'b101));
      zero_f3 = is_lui | is_auipc | is_jal | is_jalr | is_load | is_store;

      b         = '0;
      b.pc      = pc;
      b.rd      = (is_store || is_branch) ? 5'd0 : insn[11:7];
      b.rs1     = insn[19:15];
      b.rs2     = insn[24:20];
      b.imm     = XLEN'(imm32);
      b.muldiv  = md && ENABLE_M;
      b.sub_sra = alt && !b.muldiv;
      b.alu_op  = {b.sub_sra, zero_f3 ? 3'b000 : f3};
      b.use_imm = is_opimm | is_load | is_jalr | is_store | is_lui | is_auipc | is_jal;
      b.reg_we  = !bad && (is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr);
      b.mem_rd  = !bad && is_load;
      b.mem_wr  = !bad && is_store;
      b.branch  = !bad && is_branch;
      b.jump    = !bad && (is_jal || is_jalr);
      b.illegal = bad;
      return b;
   endfunction

   bundle_t out_q, out_d, skid_q, skid_d, dec;
   logic    out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic    accept, out_load;

   assign dec = decode(io.in_insn, io.in_pc);

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      accept     = io.in_valid && !skid_vld_q && !flush;
      out_load   = !out_vld_q || io.out_ready;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_load) begin
         // in_ready is low whenever the skid is occupied, so no accept competes here
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = accept;
            if (accept) out_d = dec;
         end
      end else if (accept) begin
         skid_d     = dec;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign io.in_ready  = !skid_vld_q;
   assign io.out_valid = out_vld_q;
   assign io.out_pc    = out_q.pc;
   assign io.rd        = out_q.rd;
   assign io.rs1       = out_q.rs1;
   assign io.rs2       = out_q.rs2;
   assign io.imm       = out_q.imm;
   assign io.alu_op    = out_q.alu_op;
   assign io.sub_sra   = out_q.sub_sra;
   assign io.use_imm   = out_q.use_imm;
   assign io.reg_we    = out_q.reg_we;
   assign io.mem_rd    = out_q.mem_rd;
   assign io.mem_wr    = out_q.mem_wr;
   assign io.branch    = out_q.branch;
   assign io.jump      = out_q.jump;
   assign io.muldiv    = out_q.muldiv;
   assign io.illegal   = out_q.illegal;

endmodule

// File: doc/insn_decode_stage.md
Name: insn_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage: accepts one fetched instruction per handshake and decodes all base formats (R, I, S, B, U, J).
- Produces register indices, a sign-extended immediate, a 4-bit ALU op with a generalised sub_sra bit, and control strobes.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a 2-entry skid buffer so in_ready is a registered signal.
- Optional M-extension decode.

Parameters:
- XLEN, 32, width of pc and imm; immediates sign-extend to XLEN.
- ENABLE_M, 0, 1 makes funct7=0000001 on OP legal (muldiv=1); 0 flags it illegal.

Ports:
- clk  in  1  processor clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held/in-flight entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; registered, 1 while skid buffer is empty.
- in_insn  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  pc of the decoded instruction.
- rd, rs1, rs2  out  5 each  insn[11:7], insn[19:15], insn[24:20]; rd forced 0 for S/B.
- imm  out  XLEN  sign-extended immediate per format; 0 for R.
- alu_op  out  4  {sub_sra, funct3}; U/J/load/store/JALR force funct3=000.
- sub_sra  out  1  subtract/arith-shift/compare select.
- use_imm, reg_we, mem_rd, mem_wr, branch, jump, muldiv, illegal  out  1 each  control strobes.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, all bundle outputs 0, skid buffer empty, in_ready=1 on deassertion.
- Latency: an input accepted at edge N (in_valid & in_ready) appears on the outputs with out_valid=1 after edge N.
- Output register: loads when empty or (out_valid & out_ready). Contents are held bit-stable while out_valid & !out_ready.
- Skid buffer:
  - If an input is accepted while the output register is stalled, the decoded bundle goes to the skid entry and in_ready=0 next cycle.
  - When the output drains, the skid entry moves to the output and in_ready returns to 1 the following cycle.
  - No bundle is lost or duplicated.
- Throughput: 1 instruction per cycle when out_ready is held 1.
- sub_sra=1 for:
  - OP with insn[30]=1 and funct3 in {000, 101}.
  - OP-IMM funct3=101 with insn[30]=1.
  - Any OP/OP-IMM with funct3 in {010, 011}.
  - All BRANCH.
  - Otherwise 0, including muldiv, where alu_op={0, funct3}.
- Illegal cases:
  - Unknown opcode.
  - OP funct7 not 0000000/0100000, or funct7=0100000 with funct3 not 000/101 (funct7=0000001 is legal only if ENABLE_M).
  - OP-IMM shifts with insn[31:25] not 0000000/0100000, or 0100000 on SLLI.
  - JALR funct3≠000.
  - Load funct3 in {011, 110, 111}; store funct3>010; branch funct3 in {010, 011}.
- An illegal instruction still flows with illegal=1 and reg_we=mem_rd=mem_wr=branch=jump=muldiv=0.
- Strobes:
  - reg_we for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
  - use_imm for all formats except R and B.
  - jump for JAL/JALR.
- Flush:
  - At the next edge, out_valid=0 and the skid buffer is emptied; in_ready=1 the cycle after.
  - An input presented in the flush cycle is dropped.
  - Flush has priority over a simultaneous accept or drain.
- Reset mid-stall: immediately out_valid=0 and in_ready=1 after release; pending entries are discarded.

Test Plan:
- ADD then SUB, out_ready=1: in 0x002081B3, then 0x402081B3 on consecutive cycles.
  - Expect alu_op=0000 then 1000, rd=3, rs1=1, rs2=2, reg_we=1, one per cycle, latency 1.
- SRAI x5,x6,3 (0x40335293): expect alu_op=1101, use_imm=1, imm=0x00000403, rd=5, rs1=6. BEQ x1,x2,-4 (0xFE208EE3): expect branch=1, sub_sra=1, imm=0xFFFFFFFC, reg_we=0.
- Backpressure: stream 4 instructions with out_ready=0 for 3 cycles.
  - Expect in_ready low after 2 accepted, output bundle stable.
  - On release, all 4 emerge in order with none lost or duplicated.
- M decode: 0x022081B3 with ENABLE_M=0 gives illegal=1, reg_we=0. With ENABLE_M=1 it gives muldiv=1, alu_op=0000, illegal=0. LW x5,-8(x2) (0xFF812283) gives mem_rd=1, imm=0xFFFFFFF8.
- Flush with both entries full while in_valid=1: expect out_valid=0 next edge, in_ready=1 one cycle later, flush-cycle input not emitted.
- Assert rst_n low asynchronously mid-stall: outputs clear without a clock edge; first post-reset input decodes correctly.
